multdiv_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares the single `multdiv` unit between two requesters, e.g. the execute stage and a secondary issue port. It latches operands and opcode, issues a one-cycle `ctrl_Mult`/`ctrl_Div` pulse, and waits for `data_resultRDY`. It then returns the result and exception to the winning requester with a one-cycle done pulse. A watchdog converts a hung operation into an exception.

---
 rtl/multdiv_arbiter.sv | 116 +++++++++++
 tb/tb_multdiv_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_arbiter.sv
// Round-robin sequencer that shares one multdiv unit between two requesters:
// capture operands, pulse start, wait for ready (with watchdog), return result.
module multdiv_arbiter #(
  parameter int TIMEOUT = 100,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        isDiv0,
  input  logic        isDiv1,
  input  logic [31:0] opA0,
  input  logic [31:0] opB0,
  input  logic [31:0] opA1,
  input  logic [31:0] opB1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        except,
  output logic        timeout,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_Mult,
  output logic        md_ctrl_Div,
  input  logic [31:0] md_result,
  input  logic        md_except,
  input  logic        md_ready,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Handshake: a requester raises reqX with stable operands and holds them until
  // it sees doneX; it drops reqX the cycle after, otherwise that is a new request.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             last;
  logic             gnt;
  logic             pick;
  logic             pick_div;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last;
    pick_div = pick ? isDiv1 : isDiv0;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      gnt          <= 1'b0;
      cnt          <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      result       <= '0;
      except       <= 1'b0;
      timeout      <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_Mult <= 1'b0;
      md_ctrl_Div  <= 1'b0;
    end else begin
      md_ctrl_Mult <= 1'b0;
      md_ctrl_Div  <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt          <= pick;
            last         <= pick;
            md_operandA  <= pick ? opA1 : opA0;
            md_operandB  <= pick ? opB1 : opB0;
            md_ctrl_Mult <= ~pick_div;
            md_ctrl_Div  <= pick_div;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A ready seen in the very first WAIT cycle may belong to an older op.
          if (cnt != '0 && md_ready) begin
            result  <= md_result;
            except  <= md_except;
            timeout <= 1'b0;
            done0   <= ~gnt;
            done1   <= gnt;
            state   <= DONE;
          end else if (cnt == TMO_LAST) begin
            result  <= '0;
            except  <= 1'b1;
            timeout <= 1'b1;
            done0   <= ~gnt;
            done1   <= gnt;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Bench for multdiv_arbiter: cycle-timeline model of grants, pulses and
// completions, a multdiv stub, and a per-cycle compare process.
module tb_multdiv_arbiter;

  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 7;
  localparam int MAXC    = 8192;

  typedef struct {
    bit          isdiv;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // WAIT index where ready is given; -1 = never
  } op_t;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        req0 = 1'b0, req1 = 1'b0, isDiv0 = 1'b0, isDiv1 = 1'b0;
  logic [31:0] opA0 = '0, opB0 = '0, opA1 = '0, opB1 = '0;
  logic [31:0] md_result = '0;
  logic        md_except = 1'b0, md_ready = 1'b0;
  logic        done0, done1, except, timeout, busy, md_ctrl_Mult, md_ctrl_Div;
  logic [31:0] result, md_operandA, md_operandB;
  logic [1:0]  state_dbg;

  multdiv_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .isDiv0(isDiv0), .isDiv1(isDiv1), .opA0(opA0), .opB0(opB0),
    .opA1(opA1), .opB1(opB1), .done0(done0), .done1(done1),
    .result(result), .except(except), .timeout(timeout), .busy(busy),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_Mult(md_ctrl_Mult), .md_ctrl_Div(md_ctrl_Div),
    .md_result(md_result), .md_except(md_except), .md_ready(md_ready),
    .state_dbg(state_dbg)
  );

  // expected timeline, indexed by cycle number
  bit          exp_busy [MAXC];
  bit          exp_done0[MAXC];
  bit          exp_done1[MAXC];
  bit          exp_mult [MAXC];
  bit          exp_div  [MAXC];
  bit          exp_zero [MAXC];
  logic [31:0] exp_res  [MAXC];
  bit          exp_exc  [MAXC];
  bit          exp_to   [MAXC];
  logic [31:0] exp_opa  [MAXC];
  logic [31:0] exp_opb  [MAXC];
  int          sched_mode[MAXC];   // 0 noise, 1 ready low, 2 ready high with value
  logic [31:0] sched_res[MAXC];
  bit          sched_exc[MAXC];

  bit          m_last = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] done_q[$];          // {who, result} per observed done
  bit          obs_exc, obs_to;
  int          obs_cyc;
  logic [32:0] popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void md_model(input op_t o, output logic [31:0] r, output bit e);
    longint p;
    if (o.isdiv) begin
      if (o.b == 32'd0) begin r = '0; e = 1'b1; end
      else begin r = $signed(o.a) / $signed(o.b); e = 1'b0; end
    end else begin
      p = longint'($signed(o.a)) * longint'($signed(o.b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end
  endfunction

  // Request sampled at the edge ending cycle c: ISSUE c+1, WAIT from c+2.
  task automatic serve(input int c, input bit w, input op_t o, output int d);
    logic [31:0] r;
    bit          e;
    m_last = w;
    if (o.lat > 0) begin
      d = c + 3 + o.lat;
      for (int k = 1; k < o.lat; k++) sched_mode[c+2+k] = 1;
      md_model(o, r, e);
      sched_mode[c+2+o.lat] = 2;
      sched_res[c+2+o.lat]  = r;
      sched_exc[c+2+o.lat]  = e;
      exp_res[d] = r; exp_exc[d] = e; exp_to[d] = 1'b0;
    end else begin
      d = c + 2 + TIMEOUT;
      for (int k = 1; k < TIMEOUT; k++) sched_mode[c+2+k] = 1;
      exp_res[d] = '0; exp_exc[d] = 1'b1; exp_to[d] = 1'b1;
    end
    for (int k = c + 1; k <= d; k++) begin
      exp_busy[k] = 1'b1; exp_opa[k] = o.a; exp_opb[k] = o.b;
    end
    if (o.isdiv) exp_div[c+1] = 1'b1; else exp_mult[c+1] = 1'b1;
    if (w) exp_done1[d] = 1'b1; else exp_done0[d] = 1'b1;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drop(input bit w);
    if (w) begin req1 = 1'b0; opA1 = $urandom; opB1 = $urandom; isDiv1 = 1'($urandom_range(0, 1)); end
    else   begin req0 = 1'b0; opA0 = $urandom; opB0 = $urandom; isDiv0 = 1'($urandom_range(0, 1)); end
  endtask

  task automatic run(input bit en0, input bit en1, input op_t o0, input op_t o1,
                     input bit stale, output int c, output int d);
    bit w;
    int d1;
    tick();
    c = cyc;
    if (en0) begin req0 = 1'b1; isDiv0 = o0.isdiv; opA0 = o0.a; opB0 = o0.b; end
    if (en1) begin req1 = 1'b1; isDiv1 = o1.isdiv; opA1 = o1.a; opB1 = o1.b; end
    w = (en0 && en1) ? ~m_last : en1;
    serve(c, w, w ? o1 : o0, d1);
    if (stale) begin
      sched_mode[c+1] = 2; sched_res[c+1] = $urandom; sched_exc[c+1] = 1'b1;
      sched_mode[c+2] = 2; sched_res[c+2] = $urandom; sched_exc[c+2] = 1'b1;
    end
    d = d1;
    if (en0 && en1) serve(d1 + 1, ~w, w ? o0 : o1, d);
    while (cyc < d1 + 1) tick();
    drop(w);
    if (en0 && en1) begin
      while (cyc < d + 1) tick();
      drop(~w);
    end
  endtask

  function automatic op_t mk(input bit isdiv, input int a, input int b, input int lat);
    op_t o;
    o.isdiv = isdiv; o.a = a; o.b = b; o.lat = lat;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    o.isdiv = 1'($urandom_range(0, 1));
    o.a = $urandom;
    o.b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
    if (o.b == 32'hFFFF_FFFF) o.b = 32'd7;
    r = $urandom_range(0, 19);
    if (r == 0)      o.lat = -1;
    else if (r == 1) o.lat = TIMEOUT - 1;
    else             o.lat = $urandom_range(1, 8);
    return o;
  endfunction

  // multdiv stub
  initial forever begin
    @(posedge clock);
    #2;
    if (cyc < MAXC) begin
      case (sched_mode[cyc])
        2: begin md_ready = 1'b1; md_result = sched_res[cyc]; md_except = sched_exc[cyc]; end
        1: begin md_ready = 1'b0; md_result = $urandom; md_except = 1'($urandom_range(0, 1)); end
        default: begin
          md_ready = 1'($urandom_range(0, 1)); md_result = $urandom;
          md_except = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // scoreboard / compare process
  logic [31:0] held_res = '0;
  bit          held_exc = 1'b0, held_to = 1'b0;
  initial forever begin
    int n;
    @(negedge clock);
    n = cyc;
    if (n >= MAXC - 4) begin
      errors++;
      $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", n, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    if (n >= 1) begin
      if (exp_zero[n]) begin
        held_res = '0; held_exc = 1'b0; held_to = 1'b0;
        chk("rst_opA", md_operandA, 32'd0);
        chk("rst_opB", md_operandB, 32'd0);
      end
      if (exp_done0[n] || exp_done1[n]) begin
        held_res = exp_res[n]; held_exc = exp_exc[n]; held_to = exp_to[n];
      end
      chk("busy", busy, exp_busy[n]);
      chk("done0", done0, exp_done0[n]);
      chk("done1", done1, exp_done1[n]);
      chk("ctrl_mult", md_ctrl_Mult, exp_mult[n]);
      chk("ctrl_div", md_ctrl_Div, exp_div[n]);
      chk("result", result, held_res);
      chk("except", except, held_exc);
      chk("timeout", timeout, held_to);
      if (exp_busy[n]) begin
        chk("opA", md_operandA, exp_opa[n]);
        chk("opB", md_operandB, exp_opb[n]);
      end
      if (done0 || done1) begin
        done_q.push_back({done1, result});
        obs_exc = except; obs_to = timeout; obs_cyc = n;
      end
    end
  end

  task automatic pin_next(input string name, input bit who, input logic [31:0] res);
    if (done_q.size() == 0) begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end else begin
      popped = done_q.pop_front();
      chk({name, "_who"}, popped[32], who);
      chk({name, "_res"}, popped[31:0], res);
    end
  endtask

  op_t dmy;
  initial begin
    int c, d;
    dmy = mk(1'b0, 0, 0, 1);
    exp_zero[1] = 1'b1; exp_zero[2] = 1'b1; exp_zero[3] = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // single multiply, 7 * -6
    run(1'b1, 1'b0, mk(1'b0, 7, -6, 2), dmy, 1'b0, c, d);
    pin_next("mult", 1'b0, 32'hFFFF_FFD6);
    chk("mult_exc", obs_exc, 1'b0);
    chk("mult_to", obs_to, 1'b0);

    // divide by zero on requester 1
    run(1'b0, 1'b1, dmy, mk(1'b1, 100, 0, 3), 1'b0, c, d);
    pin_next("div0", 1'b1, 32'd0);
    chk("div0_exc", obs_exc, 1'b1);

    // tie with last = 1: requester 0 first
    run(1'b1, 1'b1, mk(1'b0, 3, 4, 1), mk(1'b1, 20, 5, 2), 1'b0, c, d);
    pin_next("tie_a", 1'b0, 32'd12);
    pin_next("tie_b", 1'b1, 32'd4);

    // make last = 0, then tie: requester 1 first
    run(1'b1, 1'b0, mk(1'b0, 2, 2, 1), dmy, 1'b0, c, d);
    pin_next("prep", 1'b0, 32'd4);
    run(1'b1, 1'b1, mk(1'b0, -8, 9, 2), mk(1'b1, 81, 9, 1), 1'b0, c, d);
    pin_next("tie2_a", 1'b1, 32'd9);
    pin_next("tie2_b", 1'b0, 32'hFFFF_FFB8);

    // watchdog
    run(1'b1, 1'b0, mk(1'b0, 5, 5, -1), dmy, 1'b0, c, d);
    pin_next("wdog", 1'b0, 32'd0);
    chk("wdog_exc", obs_exc, 1'b1);
    chk("wdog_to", obs_to, 1'b1);
    chk("wdog_lat", obs_cyc - (c + 1), TIMEOUT + 1);

    // ready on the same edge the watchdog would fire: ready wins
    run(1'b0, 1'b1, dmy, mk(1'b0, 6, 7, TIMEOUT - 1), 1'b0, c, d);
    pin_next("coincide", 1'b1, 32'd42);
    chk("coincide_to", obs_to, 1'b0);

    // stale ready through ISSUE and first WAIT cycle
    run(1'b1, 1'b0, mk(1'b1, -50, 7, 1), dmy, 1'b1, c, d);
    pin_next("stale", 1'b0, 32'hFFFF_FFF9);
    chk("stale_lat", obs_cyc - c, 4);

    // reset in WAIT index 3
    tick();
    c = cyc;
    req1 = 1'b1; isDiv1 = 1'b0; opA1 = 32'd11; opB1 = 32'd13;
    serve(c, 1'b1, mk(1'b0, 11, 13, -1), d);
    while (cyc < c + 5) tick();
    reset = 1'b1;
    for (int k = c + 6; k <= d + 1; k++) begin
      exp_busy[k] = 1'b0; exp_done0[k] = 1'b0; exp_done1[k] = 1'b0; sched_mode[k] = 0;
    end
    exp_zero[c+6] = 1'b1;
    m_last = 1'b1;
    tick();
    reset = 1'b0;
    drop(1'b1);
    chk("rst_no_done", done_q.size(), 0);
    run(1'b1, 1'b1, mk(1'b0, 10, 10, 2), mk(1'b1, 9, 3, 1), 1'b0, c, d);
    pin_next("post_rst_a", 1'b0, 32'd100);
    pin_next("post_rst_b", 1'b1, 32'd3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int  sel;
      op_t o0, o1;
      sel = $urandom_range(0, 2);
      o0 = rand_op();
      o1 = rand_op();
      run(sel != 1, sel != 0, o0, o1, $urandom_range(0, 3) == 0, c, d);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
